// File: rtl/ldr_writeback_pipe_pkg.sv
// Purpose: shared types, opcode constants and load decode for the load write-back pipe.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package ldr_writeback_pipe_pkg;

    // Entries carry addresses at a fixed maximum width so the struct can live
    // in the package; the top narrows them back to RW at its ports.
    localparam int ADDR_MAX_W = 8;

    localparam logic [2:0] OPC_LD_HI  = 3'b110;
    localparam logic [3:0] OPC_LD_ALT = 4'b1000;

    typedef logic [ADDR_MAX_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        reg_addr_t rn;
        logic      wb_base;
        logic      tag;
    } ldwb_entry_t;

    // Only opcode bits [6:3] take part in the load decode.
    function automatic logic is_load(input logic [3:0] opc_hi);
        return (opc_hi[3:1] == OPC_LD_HI) | (opc_hi == OPC_LD_ALT);
    endfunction

endpackage

// File: rtl/ldr_writeback_pipe_stage.sv
// Purpose: one pipeline register of the load write-back pipe (ldwb_stage).
// Latency: 1 cycle, d to q.
// Backpressure: none; the stage loads every cycle, kill clears the captured valid.
//
// Ports: clk, rst_n (async active-low), d (incoming entry), kill (drop the
// incoming entry's valid), q (registered entry).
module ldwb_stage
    import ldr_writeback_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  ldwb_entry_t d,
    input  logic        kill,
    output ldwb_entry_t q
);

    ldwb_entry_t nxt;

    always_comb begin
        nxt       = d;
        nxt.valid = d.valid & ~kill;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/ldr_writeback_pipe.sv
// Purpose: tracks in-flight loads through DEPTH stages, issues rd/base RF write enables, exposes a load-use scoreboard.
// Latency: DEPTH cycles from the capture edge to w_en_ldr/w_en_base (the tail outputs are registered).
// Backpressure: none; the pipe advances every cycle, sel_stall injects a bubble, branch mismatch squashes.
//
// Ports: opcode_decoded/rd_in/rn_in/P_in/W_in/branch_in/sel_stall describe the
// entering slot; branch_ref is the current architectural tag; chk_addr_a/b are
// the source registers the issue stage wants checked. Outputs are the two RF
// write ports (ldr = load data, base = base update), the tail branch tag,
// the two hazard flags and the count of live in-flight loads.
module ldr_writeback_pipe
    import ldr_writeback_pipe_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int NREG  = 16,
    parameter int RW    = 4,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [6:0]    opcode_decoded,
    input  logic [RW-1:0] rd_in,
    input  logic [RW-1:0] rn_in,
    input  logic          P_in,
    input  logic          W_in,
    input  logic          branch_in,
    input  logic          branch_ref,
    input  logic          sel_stall,
    input  logic [RW-1:0] chk_addr_a,
    input  logic [RW-1:0] chk_addr_b,
    output logic          w_en_ldr,
    output logic [RW-1:0] w_addr_ldr,
    output logic          w_en_base,
    output logic [RW-1:0] w_addr_base,
    output logic          branch_value,
    output logic          hazard_a,
    output logic          hazard_b,
    output logic [CW-1:0] pending_cnt
);

    // ------------------------------------------------------------------
    // Capture decode
    // ------------------------------------------------------------------
    logic        is_ld;
    logic        unused_opc_lo;
    ldwb_entry_t cap;

    assign is_ld         = is_load(opcode_decoded[6:3]);
    assign unused_opc_lo = ^opcode_decoded[2:0];

    always_comb begin
        cap         = '0;
        cap.valid   = is_ld;
        cap.rd      = reg_addr_t'(rd_in);
        cap.rn      = reg_addr_t'(rn_in);
        // Post-index (P=0) always writes the base back; pre-index only with W.
        cap.wb_base = is_ld & (W_in | ~P_in);
        cap.tag     = branch_in;
    end

    // ------------------------------------------------------------------
    // Stage chain. A stage is live only while its tag still matches the
    // architectural tag; a non-live entry still moves on but its valid is
    // cleared by the next stage, so it can never reach the write ports.
    // ------------------------------------------------------------------
    ldwb_entry_t      stg [DEPTH];
    logic [DEPTH-1:0] live;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = stg[i].valid & (stg[i].tag == branch_ref);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        ldwb_entry_t d;
        logic        kill;

        if (i == 0) begin : g_head
            assign d    = cap;
            assign kill = sel_stall;
        end else begin : g_body
            assign d    = stg[i-1];
            assign kill = ~live[i-1];
        end

        ldwb_stage u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (d),
            .kill  (kill),
            .q     (stg[i])
        );
    end

    // ------------------------------------------------------------------
    // Tail output register: the write cycle itself. Addresses are zeroed
    // whenever their enable is low.
    // ------------------------------------------------------------------
    logic t_live;
    logic t_base;

    assign t_live = live[DEPTH-1];
    assign t_base = t_live & stg[DEPTH-1].wb_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en_ldr     <= 1'b0;
            w_addr_ldr   <= '0;
            w_en_base    <= 1'b0;
            w_addr_base  <= '0;
            branch_value <= 1'b0;
        end else begin
            w_en_ldr     <= t_live;
            w_addr_ldr   <= t_live ? stg[DEPTH-1].rd[RW-1:0] : '0;
            w_en_base    <= t_base;
            w_addr_base  <= t_base ? stg[DEPTH-1].rn[RW-1:0] : '0;
            branch_value <= stg[DEPTH-1].tag;
        end
    end

    // The load stays pending through its write cycle; w_en_ldr is only set
    // for a live entry, so it doubles as the tail valid bit.
    logic tail_live;
    assign tail_live = w_en_ldr & (branch_value == branch_ref);

    // ------------------------------------------------------------------
    // Load-use scoreboard and in-flight count. Addresses at or above NREG
    // do not name a tracked register and never report a hazard.
    // ------------------------------------------------------------------
    logic a_tracked;
    logic b_tracked;

    assign a_tracked = int'(chk_addr_a) < NREG;
    assign b_tracked = int'(chk_addr_b) < NREG;

    always_comb begin
        hazard_a    = tail_live & (w_addr_ldr == chk_addr_a);
        hazard_b    = tail_live & (w_addr_ldr == chk_addr_b);
        pending_cnt = CW'(tail_live);
        for (int i = 0; i < DEPTH; i++) begin
            hazard_a    = hazard_a | (live[i] & (stg[i].rd == reg_addr_t'(chk_addr_a)));
            hazard_b    = hazard_b | (live[i] & (stg[i].rd == reg_addr_t'(chk_addr_b)));
            pending_cnt = pending_cnt + CW'(live[i]);
        end
        hazard_a = hazard_a & a_tracked;
        hazard_b = hazard_b & b_tracked;
    end

endmodule

// File: tb/tb_ldr_writeback_pipe.sv
// Purpose: self-checking bench for ldr_writeback_pipe with a write-port scoreboard.
// Latency: expects the write DEPTH cycles after the capture edge.
// Backpressure: n/a (the design has none).
module tb_ldr_writeback_pipe;

    localparam int DEPTH = 3;
    localparam int NREG  = 16;
    localparam int RW    = 4;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    opcode_decoded;
    logic [RW-1:0] rd_in;
    logic [RW-1:0] rn_in;
    logic          P_in;
    logic          W_in;
    logic          branch_in;
    logic          branch_ref;
    logic          sel_stall;
    logic [RW-1:0] chk_addr_a;
    logic [RW-1:0] chk_addr_b;
    logic          w_en_ldr;
    logic [RW-1:0] w_addr_ldr;
    logic          w_en_base;
    logic [RW-1:0] w_addr_base;
    logic          branch_value;
    logic          hazard_a;
    logic          hazard_b;
    logic [CW-1:0] pending_cnt;

    ldr_writeback_pipe #(.DEPTH(DEPTH), .NREG(NREG), .RW(RW), .CW(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode_decoded (opcode_decoded),
        .rd_in          (rd_in),
        .rn_in          (rn_in),
        .P_in           (P_in),
        .W_in           (W_in),
        .branch_in      (branch_in),
        .branch_ref     (branch_ref),
        .sel_stall      (sel_stall),
        .chk_addr_a     (chk_addr_a),
        .chk_addr_b     (chk_addr_b),
        .w_en_ldr       (w_en_ldr),
        .w_addr_ldr     (w_addr_ldr),
        .w_en_base      (w_en_base),
        .w_addr_base    (w_addr_base),
        .branch_value   (branch_value),
        .hazard_a       (hazard_a),
        .hazard_b       (hazard_b),
        .pending_cnt    (pending_cnt)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int rd;
        int ben;
        int rn;
        int tag;
    } exp_t;

    exp_t expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write cycle must match the oldest expected write.
    exp_t e;
    always @(negedge clk) begin
        if (w_en_ldr) begin
            if (expq.size() == 0) begin
                check("unexpected_write", 32'(w_en_ldr), 32'd0);
            end else begin
                e = expq.pop_front();
                check("wr_cycle",     cyc,                 e.cyc);
                check("w_addr_ldr",   32'(w_addr_ldr),     e.rd);
                check("w_en_base",    32'(w_en_base),      e.ben);
                check("w_addr_base",  32'(w_addr_base),    e.rn);
                check("branch_value", 32'(branch_value),   e.tag);
            end
        end else if (w_en_base) begin
            check("base_without_ldr", 32'(w_en_base), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one slot at a negedge; it is captured on the following posedge.
    // exp_ben / exp_rn are the hand-computed base-port values for the write.
    task automatic issue(input logic [6:0] opc, input int rd, input int rn,
                         input logic p, input logic w, input logic tag,
                         input logic stall, input bit exp_wr,
                         input int exp_ben, input int exp_rn);
        opcode_decoded = opc;
        rd_in          = RW'(rd);
        rn_in          = RW'(rn);
        P_in           = p;
        W_in           = w;
        branch_in      = tag;
        sel_stall      = stall;
        if (exp_wr) expq.push_back('{cyc + 1 + DEPTH, rd, exp_ben, exp_rn, int'(tag)});
        @(negedge clk);
        opcode_decoded = 7'b0000000;
        sel_stall      = 1'b1;
        branch_in      = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        opcode_decoded = 7'b0000000;
        rd_in          = '0;
        rn_in          = '0;
        P_in           = 1'b1;
        W_in           = 1'b0;
        branch_in      = 1'b0;
        branch_ref     = 1'b0;
        sel_stall      = 1'b1;
        chk_addr_a     = '0;
        chk_addr_b     = '0;

        tick(2);
        check("rst_w_en_ldr",     32'(w_en_ldr),     0);
        check("rst_w_addr_ldr",   32'(w_addr_ldr),   0);
        check("rst_w_en_base",    32'(w_en_base),    0);
        check("rst_w_addr_base",  32'(w_addr_base),  0);
        check("rst_branch_value", 32'(branch_value), 0);
        check("rst_hazard_a",     32'(hazard_a),     0);
        check("rst_hazard_b",     32'(hazard_b),     0);
        check("rst_pending",      32'(pending_cnt),  0);
        rst_n = 1'b1;
        tick(2);

        // 1: plain LDR rd=5, pre-index no write-back; hazard cycles 0..3.
        chk_addr_a = 4'd5;
        issue(7'b1100000, 5, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        for (int k = 0; k <= 3; k++) begin
            check("t1_hazard_a_pending", 32'(hazard_a), 1);
            if (k < 3) tick(1);
        end
        check("t1_pending_tail", 32'(pending_cnt), 1);
        tick(1);
        check("t1_hazard_a_clear", 32'(hazard_a), 0);
        check("t1_pending_clear",  32'(pending_cnt), 0);
        tick(2);

        // 2: post-index load rd=2 rn=7 writes both ports together.
        chk_addr_b = 4'd2;
        chk_addr_a = 4'd7;
        issue(7'b1000101, 2, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 7);
        check("t2_hazard_b", 32'(hazard_b), 1);
        check("t2_hazard_a_rn_not_pending", 32'(hazard_a), 0);
        tick(4);

        // 2b: pre-index with write-back, rd == rn.
        issue(7'b1101111, 4, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 4);
        tick(4);

        // 3: back-to-back loads rd=1,2,3.
        chk_addr_a = 4'd0;
        chk_addr_b = 4'd0;
        issue(7'b1100000, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        issue(7'b1100000, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        issue(7'b1100000, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        check("t3_pending_3", 32'(pending_cnt), 3);
        tick(1);
        check("t3_pending_first_tail", 32'(pending_cnt), 3);
        tick(1);
        check("t3_pending_2", 32'(pending_cnt), 2);
        tick(2);
        check("t3_pending_0", 32'(pending_cnt), 0);
        tick(1);

        // 4: squash by branch flip; then a load carrying the new tag survives.
        chk_addr_a = 4'd9;
        issue(7'b1100000, 9, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("t4_pending_before", 32'(pending_cnt), 1);
        check("t4_hazard_before",  32'(hazard_a), 1);
        tick(1);
        branch_ref = 1'b1;
        #1;
        check("t4_hazard_nonlive", 32'(hazard_a), 0);
        tick(1);
        check("t4_hazard_after",  32'(hazard_a), 0);
        check("t4_pending_after", 32'(pending_cnt), 0);
        branch_ref = 1'b0;
        tick(4);
        branch_ref = 1'b1;
        issue(7'b1100000, 6, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
        tick(4);
        branch_ref = 1'b0;
        tick(1);

        // 5: bubble with a load opcode, then a non-load opcode.
        chk_addr_a = 4'd10;
        issue(7'b1100000, 10, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        check("t5_stall_pending", 32'(pending_cnt), 0);
        check("t5_stall_hazard",  32'(hazard_a), 0);
        issue(7'b0000000, 10, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("t5_nonload_pending", 32'(pending_cnt), 0);
        check("t5_nonload_hazard",  32'(hazard_a), 0);
        tick(4);

        // 6: reset while the first load is writing and the second is in flight.
        chk_addr_a = 4'd12;
        issue(7'b1100000, 11, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        issue(7'b1000000, 12, 13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 13);
        tick(2);
        check("t6_pending_pre_rst", 32'(pending_cnt), 2);
        check("t6_hazard_pre_rst",  32'(hazard_a), 1);
        #2;
        rst_n = 1'b0;
        expq.delete();
        #1;
        check("t6_rst_w_en_ldr",   32'(w_en_ldr),    0);
        check("t6_rst_w_addr_ldr", 32'(w_addr_ldr),  0);
        check("t6_rst_w_en_base",  32'(w_en_base),   0);
        check("t6_rst_hazard_a",   32'(hazard_a),    0);
        check("t6_rst_pending",    32'(pending_cnt), 0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("t6_post_rst_pending", 32'(pending_cnt), 0);

        check("missing_writes", 32'(expq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
